// File: rtl/commit_trace_buffer.sv
// Commit-trace capture buffer for the RV32I core.
// Records retired instructions (PC, instruction word, write-back) into a circular buffer
// that is drained through a first-word-fall-through valid/ready stream. Supports a PC-match
// trigger, stop-or-wrap capture modes and a saturating drop counter.
// Optional feature: define TRACE_TIMESTAMP_EN to add a per-entry cycle timestamp (o_trace_ts).
module commit_trace_buffer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 8,
  parameter int unsigned TS_W   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_capture_en,
  input  logic                       i_wrap_mode,
  input  logic                       i_trig_en,
  input  logic [XLEN-1:0]            i_trig_pc,
  input  logic                       i_insn_vld,
  input  logic [XLEN-1:0]            i_pc,
  input  logic [31:0]                i_inst,
  input  logic                       i_rd_wren,
  input  logic [4:0]                 i_rd_addr,
  input  logic [XLEN-1:0]            i_rd_data,
  output logic                       o_trace_vld,
  input  logic                       i_trace_rdy,
  output logic [XLEN-1:0]            o_trace_pc,
  output logic [31:0]                o_trace_inst,
  output logic [4:0]                 o_trace_rd,
  output logic [XLEN-1:0]            o_trace_rd_data,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]            o_trace_ts,
`endif
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [DROP_W-1:0]          o_drop_cnt,
  output logic [1:0]                 o_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StArmed   = 2'b01,
    StCapture = 2'b10,
    StStopped = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [DROP_W-1:0]   drop_q;

  logic [XLEN-1:0]     pc_mem   [DEPTH];
  logic [31:0]         inst_mem [DEPTH];
  logic [4:0]          rd_mem   [DEPTH];
  logic [XLEN-1:0]     data_mem [DEPTH];

  logic empty, full, pop, push_req, do_write, overwrite, drop_evt;
  logic [4:0]      rd_sel;
  logic [XLEN-1:0] rd_data_sel;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCnt);
  assign pop   = ~empty & i_trace_rdy;

  // The ARMED match cycle pushes the matching instruction itself.
  assign push_req = i_capture_en & i_insn_vld &
                    ((state_q == StCapture) | ((state_q == StArmed) & (i_pc == i_trig_pc)));
  // A full buffer accepts a push only if the head leaves this cycle or oldest is overwritten.
  assign do_write  = push_req & (~full | pop | i_wrap_mode);
  assign overwrite = push_req & full & ~pop & i_wrap_mode;
  assign drop_evt  = (i_capture_en & i_insn_vld & (state_q == StStopped)) |
                     (push_req & full & ~pop);

  assign rd_sel      = (i_rd_wren && (i_rd_addr != 5'd0)) ? i_rd_addr : 5'd0;
  assign rd_data_sel = (rd_sel != 5'd0) ? i_rd_data : '0;

  // Next-state logic; dropping capture enable overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (i_capture_en) state_d = i_trig_en ? StArmed : StCapture;
      StArmed:   if (i_insn_vld && (i_pc == i_trig_pc)) state_d = StCapture;
      StCapture: if (push_req && !pop && !i_wrap_mode && (count_q == FullCnt - CW'(1)))
                   state_d = StStopped;
      StStopped: if (!full) state_d = StCapture;
      default:   state_d = StIdle;
    endcase
    if (!i_capture_en) state_d = StIdle;
  end

  // State, pointers, occupancy and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      if (do_write) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop || overwrite) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_write && !pop && !full) count_q <= count_q + CW'(1);
      else if (pop && !do_write)     count_q <= count_q - CW'(1);
      if (drop_evt && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      pc_mem[wr_ptr_q]   <= i_pc;
      inst_mem[wr_ptr_q] <= i_inst;
      rd_mem[wr_ptr_q]   <= rd_sel;
      data_mem[wr_ptr_q] <= rd_data_sel;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_mem [DEPTH];

  // Free-running cycle counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) ts_q <= '0;
    else          ts_q <= ts_q + TS_W'(1);
  end

  // Timestamp captured alongside each entry.
  always_ff @(posedge i_clk) begin
    if (do_write) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign o_trace_ts = empty ? '0 : ts_mem[rd_ptr_q];
`else
  logic unused_ts_w;
  assign unused_ts_w = ^TS_W;
`endif

  // Head outputs read as zero whenever the buffer is empty.
  always_comb begin
    o_trace_vld     = ~empty;
    o_trace_pc      = empty ? '0 : pc_mem[rd_ptr_q];
    o_trace_inst    = empty ? '0 : inst_mem[rd_ptr_q];
    o_trace_rd      = empty ? '0 : rd_mem[rd_ptr_q];
    o_trace_rd_data = empty ? '0 : data_mem[rd_ptr_q];
    o_count         = count_q;
    o_full          = full;
    o_empty         = empty;
    o_drop_cnt      = drop_q;
    o_state         = state_q;
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: a queue-based reference model of the trace
// buffer, directed scenarios for the documented cases, then randomized traffic.
module tb_commit_trace_buffer;
  localparam int XLEN = 32, DEPTH = 16, DROP_W = 8, TS_W = 16;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic capture_en = 0, wrap_mode = 0, trig_en = 0, insn_vld = 0, rd_wren = 0, trace_rdy = 0;
  logic [31:0] trig_pc = 0, pc = 0, inst = 0, rd_data = 0;
  logic [4:0]  rd_addr = 0;
  logic        o_trace_vld, o_full, o_empty;
  logic [31:0] o_trace_pc, o_trace_inst, o_trace_rd_data;
  logic [4:0]  o_trace_rd, o_count;
  logic [7:0]  o_drop_cnt;
  logic [1:0]  o_state;
  logic [TS_W-1:0] o_trace_ts;

  always #5 clk = ~clk;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .DROP_W(DROP_W), .TS_W(TS_W)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_capture_en(capture_en), .i_wrap_mode(wrap_mode),
    .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_insn_vld(insn_vld), .i_pc(pc),
    .i_inst(inst), .i_rd_wren(rd_wren), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_trace_vld(o_trace_vld), .i_trace_rdy(trace_rdy), .o_trace_pc(o_trace_pc),
    .o_trace_inst(o_trace_inst), .o_trace_rd(o_trace_rd), .o_trace_rd_data(o_trace_rd_data),
`ifdef TRACE_TIMESTAMP_EN
    .o_trace_ts(o_trace_ts),
`endif
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_drop_cnt(o_drop_cnt),
    .o_state(o_state)
  );
`ifndef TRACE_TIMESTAMP_EN
  assign o_trace_ts = '0;
`endif

  typedef struct {
    logic [31:0] pc; logic [31:0] inst; logic [4:0] rd; logic [31:0] data; logic [TS_W-1:0] ts;
  } ent_t;

  ent_t            sb_q[$];     // expected trace contents, oldest first
  int              m_state;     // 0 idle, 1 armed, 2 capture, 3 stopped
  int              m_drop;
  logic [TS_W-1:0] m_ts;
  int n_cmp = 0, n_bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void add_drop();
    if (m_drop < DROP_MAX) m_drop++;
  endfunction

  // Reference model: applies the buffer rules to the inputs seen at each rising edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      sb_q.delete(); m_state = 0; m_drop = 0; m_ts = '0;
    end else begin
      int old; bit popped, pushed, preq; ent_t e;
      old    = sb_q.size();
      popped = (old > 0) && trace_rdy;
      preq   = capture_en && insn_vld && (m_state == 2 || (m_state == 1 && pc == trig_pc));
      pushed = 0;
      e.pc   = pc; e.inst = inst; e.ts = m_ts;
      e.rd   = (rd_wren && rd_addr != 0) ? rd_addr : 5'd0;
      e.data = (e.rd != 0) ? rd_data : 32'd0;
      if (popped) void'(sb_q.pop_front());
      if (preq) begin
        if (old < DEPTH || popped) begin sb_q.push_back(e); pushed = 1; end
        else if (wrap_mode) begin
          void'(sb_q.pop_front()); sb_q.push_back(e); pushed = 1; add_drop();
        end else add_drop();
      end
      if (capture_en && insn_vld && m_state == 3) add_drop();
      if (!capture_en) m_state = 0;
      else case (m_state)
        0: m_state = trig_en ? 1 : 2;
        1: if (insn_vld && pc == trig_pc) m_state = 2;
        2: if (pushed && !wrap_mode && old < DEPTH && sb_q.size() == DEPTH) m_state = 3;
        3: if (old < DEPTH) m_state = 2;
        default: m_state = 0;
      endcase
      m_ts = m_ts + 1'b1;
    end
  end

  // Monitor: on each falling edge compare the presented head and status against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("state", o_state, m_state);
      chk("count", o_count, sb_q.size());
      chk("empty", o_empty, sb_q.size() == 0);
      chk("full", o_full, sb_q.size() == DEPTH);
      chk("drop_cnt", o_drop_cnt, m_drop);
      chk("trace_vld", o_trace_vld, sb_q.size() != 0);
      if (sb_q.size() != 0) begin
        chk("head_pc", o_trace_pc, sb_q[0].pc);
        chk("head_inst", o_trace_inst, sb_q[0].inst);
        chk("head_rd", o_trace_rd, sb_q[0].rd);
        chk("head_rd_data", o_trace_rd_data, sb_q[0].data);
`ifdef TRACE_TIMESTAMP_EN
        chk("head_ts", o_trace_ts, sb_q[0].ts);
`endif
      end else begin
        chk("empty_head_zero", {o_trace_pc, o_trace_inst ^ o_trace_rd_data ^ o_trace_rd}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ret(input logic v, input logic [31:0] p, input logic r);
    insn_vld = v && capture_en; pc = p; inst = $urandom; rd_wren = 1'($urandom_range(0, 1));
    rd_addr = 5'($urandom); rd_data = $urandom; trace_rdy = r;
    step();
  endtask

  task automatic do_reset();
    rst_n = 0; capture_en = 0; insn_vld = 0; trace_rdy = 0; trig_en = 0; wrap_mode = 0;
    step(); step();
    rst_n = 1;
  endtask

  initial begin
    logic [TS_W-1:0] ts0;
    // T1: free capture of three retirements, then drain.
    do_reset();
    capture_en = 1;
    ret(0, 0, 0);
    ret(1, 32'h0, 0); ret(1, 32'h4, 0); ret(1, 32'h8, 0);
    chk("t1_count", o_count, 3);
    chk("t1_head", o_trace_pc, 32'h0);
`ifdef TRACE_TIMESTAMP_EN
    ts0 = o_trace_ts;
    ret(0, 0, 1);
    chk("t1_ts_step", 64'(o_trace_ts - ts0), 1);
    ret(0, 0, 1); ret(0, 0, 1);
`else
    ts0 = '0;
    ret(0, 0, 1); ret(0, 0, 1); ret(0, 0, 1);
`endif
    chk("t1_empty", o_empty, 1);

    // T2: PC trigger.
    do_reset();
    capture_en = 1; trig_en = 1; trig_pc = 32'h10;
    ret(0, 0, 0);
    chk("t2_armed", o_state, 2'b01);
    for (int i = 0; i < 8; i++) ret(1, 32'(4 * i), 0);
    chk("t2_capture", o_state, 2'b10);
    chk("t2_count", o_count, 4);
    chk("t2_head", o_trace_pc, 32'h10);

    // T3: stop-when-full, then saturate the drop counter, then resume.
    do_reset();
    capture_en = 1;
    ret(0, 0, 0);
    for (int i = 0; i < DEPTH + 3; i++) ret(1, 32'h100 + 32'(4 * i), 0);
    chk("t3_full", o_full, 1);
    chk("t3_stopped", o_state, 2'b11);
    chk("t3_drop", o_drop_cnt, 3);
    chk("t3_head", o_trace_pc, 32'h100);
    for (int i = 0; i < 300; i++) ret(1, 32'h900, 0);
    chk("t3_drop_sat", o_drop_cnt, DROP_MAX);
    ret(0, 0, 1);
    ret(0, 0, 0);
    chk("t3_resume", o_state, 2'b10);

    // T4: wrap mode overwrites oldest.
    do_reset();
    capture_en = 1; wrap_mode = 1;
    ret(0, 0, 0);
    for (int i = 0; i < DEPTH + 3; i++) ret(1, 32'h200 + 32'(4 * i), 0);
    chk("t4_count", o_count, DEPTH);
    chk("t4_drop", o_drop_cnt, 3);
    chk("t4_head", o_trace_pc, 32'h20c);

    // T5: push and pop together while full; rd=x0 write-back reads as zero.
    insn_vld = 1; pc = 32'h500; inst = 32'h13; rd_wren = 1; rd_addr = 0; rd_data = 32'hdead;
    trace_rdy = 1;
    step();
    chk("t5_count", o_count, DEPTH);
    chk("t5_drop", o_drop_cnt, 3);
    for (int i = 0; i < DEPTH - 1; i++) ret(0, 0, 1);
    chk("t5_head", o_trace_pc, 32'h500);
    chk("t5_rd", o_trace_rd, 0);
    chk("t5_rd_data", o_trace_rd_data, 0);

    // T6: asynchronous reset in the middle of capture.
    do_reset();
    capture_en = 1;
    ret(0, 0, 0);
    for (int i = 0; i < 5; i++) ret(1, 32'h300 + 32'(4 * i), 0);
    rst_n = 0;
    #1;
    chk("t6_vld", o_trace_vld, 0);
    chk("t6_pc", o_trace_pc, 0);
    chk("t6_inst", o_trace_inst, 0);
    chk("t6_count", o_count, 0);
    chk("t6_empty", o_empty, 1);
    chk("t6_state", o_state, 0);
    chk("t6_drop", o_drop_cnt, 0);
    capture_en = 0; insn_vld = 0;
    step();
    rst_n = 1;

    // Randomized traffic with occasional mode changes.
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        wrap_mode = 1'($urandom_range(0, 1));
        trig_en   = 1'($urandom_range(0, 1));
        trig_pc   = 32'(4 * $urandom_range(0, 15));
      end
      capture_en = ($urandom_range(0, 39) != 0);
      ret(($urandom_range(0, 9) < 6), 32'(4 * $urandom_range(0, 15)),
          ($urandom_range(0, 9) < (c % 512 < 256 ? 2 : 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
